cam_sccb_config: RTL and testbench

Power-up configuration sequencer for the OV-series camera that feeds the cam_data capture path. It waits for sensor power-up, then walks a register table of {reg_addr, value} entries supplied over a 1-cycle-latency lookup port, issuing each as an SCCB 3-phase write (ID, sub-address, data). It asserts cam_done_o when the whole table has been written, gating the capture/Sobel pipeline. SCCB is write-only here: the 9th (don't-care) bit is released and never sampled.

---
 rtl/cam_sccb_config.sv | 194 +++++++++++++++++++
 tb/tb_cam_sccb_config.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_sccb_config.sv
// Power-up SCCB configuration sequencer: waits for sensor power-up, then writes a
// {reg, value} table to the camera as 3-phase SCCB writes and flags completion.
module cam_sccb_config #(
    parameter int unsigned CLK_DIV    = 125,
    parameter logic [7:0]  DEV_ADDR   = 8'h42,
    parameter logic [7:0]  REG_NUM    = 8'd200,
    parameter logic [19:0] PWR_WAIT   = 20'd50000,
    parameter logic [19:0] RST_WAIT   = 20'd50000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        start_i,
    output logic [7:0]  cfg_idx_o,
    input  logic [15:0] cfg_data_i,
    output logic        sio_c_o,
    output logic        sio_d_o,
    output logic        sio_d_oe_o,
    output logic        busy_o,
    output logic        cam_done_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWR, S_FETCH, S_START, S_SHIFT, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_qcnt;
    logic [1:0]    r_q;
    logic [19:0]   r_wcnt;
    logic [3:0]    r_pos;
    logic [1:0]    r_byte;
    logic [23:0]   r_sh;
    logic          r_soft;
    logic [7:0]    r_idx;
    logic          r_auto;
    logic          r_busy;
    logic          r_done;
    logic          r_sio_c;
    logic          r_sio_d;
    logic          r_sio_oe;

    logic w_tick;
    logic w_qend;
    logic w_enter;
    logic w_last;
    logic w_pwr_end;
    logic w_dly_end;
    logic w_slot_last;
    logic w_soft_in;
    logic w_sio_c;
    logic w_sio_d;
    logic w_sio_oe;

    assign w_tick      = (r_qcnt == QMAX);
    assign w_qend      = w_tick && (r_q == 2'd3);
    assign w_enter     = (w_state_nxt != r_state);
    assign w_last      = (({1'b0, r_idx} + 9'd1) == {1'b0, REG_NUM});
    assign w_pwr_end   = (({1'b0, r_wcnt} + 21'd1) >= {1'b0, PWR_WAIT});
    assign w_dly_end   = (({1'b0, r_wcnt} + 21'd1) >= {1'b0, RST_WAIT});
    assign w_slot_last = (r_pos == 4'd8) && (r_byte == 2'd2);
    // Writing bit7 of COM7 (0x12) soft-resets the sensor; it needs time to recover.
    assign w_soft_in   = (cfg_data_i[15:8] == 8'h12) && cfg_data_i[7];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i || (AUTO_START && r_auto)) w_state_nxt = S_PWR;
            S_PWR:   if (w_pwr_end) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (r_idx == REG_NUM)   w_state_nxt = S_DONE;
                else if (r_wcnt != '0)  w_state_nxt = S_START;
            end
            S_START: if (w_qend) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_qend && w_slot_last) w_state_nxt = S_STOP;
            S_STOP:  if (w_qend) w_state_nxt = S_GAP;
            S_GAP: begin
                if (w_qend) begin
                    if (r_soft)      w_state_nxt = S_DELAY;
                    else if (w_last) w_state_nxt = S_DONE;
                    else             w_state_nxt = S_FETCH;
                end
            end
            S_DELAY: if (w_dly_end) w_state_nxt = w_last ? S_DONE : S_FETCH;
            S_DONE:  if (start_i) w_state_nxt = S_PWR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sio_c  = 1'b1;
        w_sio_d  = 1'b1;
        w_sio_oe = 1'b0;
        case (r_state)
            S_START: begin
                w_sio_oe = 1'b1;
                w_sio_d  = (r_q == 2'd0);
            end
            S_SHIFT: begin
                w_sio_c = (r_q == 2'd1) || (r_q == 2'd2);
                if (r_pos != 4'd8) begin
                    w_sio_oe = 1'b1;
                    w_sio_d  = r_sh[23];
                end
            end
            S_STOP: begin
                w_sio_oe = 1'b1;
                w_sio_c  = (r_q != 2'd0);
                w_sio_d  = r_q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state  <= S_IDLE;
            r_qcnt   <= '0;
            r_q      <= '0;
            r_wcnt   <= '0;
            r_pos    <= '0;
            r_byte   <= '0;
            r_sh     <= '0;
            r_soft   <= 1'b0;
            r_idx    <= '0;
            r_auto   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sio_c  <= 1'b1;
            r_sio_d  <= 1'b1;
            r_sio_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // Auto-start only applies to the first cycle out of reset.
            r_auto   <= 1'b0;
            r_busy   <= !(w_state_nxt inside {S_IDLE, S_DONE});
            r_done   <= (w_state_nxt == S_DONE);
            r_sio_c  <= w_sio_c;
            r_sio_d  <= w_sio_d;
            r_sio_oe <= w_sio_oe;

            if (w_enter) begin
                r_qcnt <= '0;
                r_q    <= '0;
                r_wcnt <= '0;
            end else begin
                if (w_tick) begin
                    r_qcnt <= '0;
                    r_q    <= r_q + 2'd1;
                end else begin
                    r_qcnt <= r_qcnt + 1'b1;
                end
                if (r_state inside {S_PWR, S_FETCH, S_DELAY})
                    r_wcnt <= r_wcnt + 20'd1;
            end

            if (w_enter && (w_state_nxt == S_PWR))
                r_idx <= '0;

            if ((r_state == S_FETCH) && (w_state_nxt == S_START)) begin
                r_sh   <= {DEV_ADDR, cfg_data_i};
                r_soft <= w_soft_in;
                r_pos  <= '0;
                r_byte <= '0;
            end

            // Slot 8 of each byte is the released don't-care bit: no shift.
            if ((r_state == S_SHIFT) && w_qend) begin
                if (r_pos == 4'd8) begin
                    r_pos  <= '0;
                    r_byte <= r_byte + 2'd1;
                end else begin
                    r_pos <= r_pos + 4'd1;
                    r_sh  <= {r_sh[22:0], 1'b0};
                end
            end

            if ((r_state inside {S_GAP, S_DELAY}) && (w_state_nxt inside {S_FETCH, S_DONE}))
                r_idx <= r_idx + 8'd1;
        end
    end

    assign cfg_idx_o  = r_idx;
    assign sio_c_o    = r_sio_c;
    assign sio_d_o    = r_sio_d;
    assign sio_d_oe_o = r_sio_oe;
    assign busy_o     = r_busy;
    assign cam_done_o = r_done;

endmodule

// File: tb/tb_cam_sccb_config.sv
// Bench for cam_sccb_config: bus-level SCCB decoder plus a timing/table model per instance.
module tb_cam_sccb_config;

    localparam int A_CD = 1;
    localparam int A_PW = 4;
    localparam int A_RW = 10;
    localparam int A_N  = 4;
    localparam int Z_PW = 5;
    localparam int P_CD = 125;
    localparam int P_PW = 3;
    localparam logic [7:0] DEV = 8'h42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, start_a, c_a, d_a, oe_a, busy_a, done_a;
    logic [7:0]  idx_a;
    logic [15:0] cfg_a;
    logic        rst_z, start_z, c_z, d_z, oe_z, busy_z, done_z;
    logic [7:0]  idx_z;
    logic [15:0] cfg_z;
    logic        rst_p, start_p, c_p, d_p, oe_p, busy_p, done_p;
    logic [7:0]  idx_p;
    logic [15:0] cfg_p;

    cam_sccb_config #(.CLK_DIV(A_CD), .DEV_ADDR(DEV), .REG_NUM(8'(A_N)), .PWR_WAIT(20'(A_PW)),
                      .RST_WAIT(20'(A_RW)), .AUTO_START(1'b1)) u_a (
        .sys_clk_i(clk), .sys_rst_i(rst_a), .start_i(start_a), .cfg_idx_o(idx_a),
        .cfg_data_i(cfg_a), .sio_c_o(c_a), .sio_d_o(d_a), .sio_d_oe_o(oe_a),
        .busy_o(busy_a), .cam_done_o(done_a));

    cam_sccb_config #(.CLK_DIV(2), .DEV_ADDR(DEV), .REG_NUM(8'd0), .PWR_WAIT(20'(Z_PW)),
                      .RST_WAIT(20'd7), .AUTO_START(1'b1)) u_z (
        .sys_clk_i(clk), .sys_rst_i(rst_z), .start_i(start_z), .cfg_idx_o(idx_z),
        .cfg_data_i(cfg_z), .sio_c_o(c_z), .sio_d_o(d_z), .sio_d_oe_o(oe_z),
        .busy_o(busy_z), .cam_done_o(done_z));

    cam_sccb_config #(.CLK_DIV(P_CD), .DEV_ADDR(DEV), .REG_NUM(8'd1), .PWR_WAIT(20'(P_PW)),
                      .RST_WAIT(20'd5), .AUTO_START(1'b0)) u_p (
        .sys_clk_i(clk), .sys_rst_i(rst_p), .start_i(start_p), .cfg_idx_o(idx_p),
        .cfg_data_i(cfg_p), .sio_c_o(c_p), .sio_d_o(d_p), .sio_d_oe_o(oe_p),
        .busy_o(busy_p), .cam_done_o(done_p));

    // Table ROMs with one cycle of lookup latency.
    logic [15:0] tbl_a [0:255];
    always @(posedge clk) cfg_a <= tbl_a[idx_a];
    always @(posedge clk) cfg_p <= (idx_p == 8'd0) ? 16'h1204 : 16'hFFFF;
    assign cfg_z = 16'h0000;

    // SCCB bus decoder for instance A (line reads high when released).
    logic        sda_a;
    assign sda_a = oe_a ? d_a : 1'b1;
    logic        mon_en = 1'b0;
    logic        pc = 1'b1, ps = 1'b1, inf = 1'b0;
    logic [26:0] msh = '0;
    int          mnb = 0;
    int          q_st_t[$], q_st_idx[$], q_nb[$], q_sp_t[$];
    logic [26:0] q_fr[$];

    always @(negedge clk) begin
        pc <= c_a;
        ps <= sda_a;
        if (!mon_en) begin
            inf <= 1'b0;
            mnb <= 0;
        end else if (pc && c_a && ps && !sda_a) begin
            inf <= 1'b1;
            mnb <= 0;
            msh <= '0;
            q_st_t.push_back(cyc);
            q_st_idx.push_back(int'(idx_a));
        end else if (pc && c_a && !ps && sda_a && inf) begin
            q_fr.push_back(msh);
            q_nb.push_back(mnb);
            q_sp_t.push_back(cyc);
            inf <= 1'b0;
        end else if (!pc && c_a && inf) begin
            if (mnb < 27) msh <= {msh[25:0], sda_a};
            mnb <= mnb + 1;
        end
    end

    int  n_vec = 0;
    int  n_err = 0;
    bit  found;
    int  t_b, t_d, t1, t2, t3, sb, fb, nb, nlow;
    logic [7:0] r_ig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_soft(input logic [15:0] e);
        return (e[15:8] == 8'h12) && e[7];
    endfunction

    // 27 bus bits: three bytes, each followed by a released (high) don't-care bit.
    function automatic logic [26:0] exp_frame(input logic [15:0] e);
        return {DEV, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1};
    endfunction

    function automatic int exp_done();
        int t = A_PW;
        for (int k = 0; k < A_N; k++)
            t += 2 + 120 * A_CD + (is_soft(tbl_a[k]) ? A_RW : 0);
        return t;
    endfunction

    task automatic rand_tbl(input int s);
        logic [7:0] r, v;
        for (int i = 0; i < 256; i++) tbl_a[i] = 16'h0000;
        for (int i = 0; i < A_N; i++) begin
            r = 8'($urandom);
            v = 8'($urandom);
            if (r == 8'h12) v[7] = 1'b0;
            tbl_a[i] = {r, v};
        end
        tbl_a[s] = {8'h12, 1'b1, 7'($urandom)};
        tbl_a[(s + 1) % A_N] = {8'h12, 1'b0, 7'($urandom)};
    endtask

    task automatic check_run(input int sbase, input int fbase, input int tb_, input int td_);
        int gap;
        chk("frame_count", q_fr.size() - fbase, A_N);
        for (int k = 0; k < A_N; k++) begin
            if (fbase + k < q_fr.size()) begin
                chk($sformatf("frame%0d_bits", k), q_fr[fbase + k], exp_frame(tbl_a[k]));
                chk($sformatf("frame%0d_clocks", k), q_nb[fbase + k], 28);
            end
            if (sbase + k < q_st_idx.size())
                chk($sformatf("frame%0d_idx", k), q_st_idx[sbase + k], k);
        end
        // Stop edge (q2) -> start edge (q1): 2 + 4 gap + 1 quarters, fetch, optional delay.
        for (int k = 1; k < A_N; k++) begin
            if ((sbase + k < q_st_t.size()) && (fbase + k - 1 < q_sp_t.size())) begin
                gap = 7 * A_CD + 2 + (is_soft(tbl_a[k - 1]) ? A_RW : 0);
                chk($sformatf("gap%0d", k), q_st_t[sbase + k] - q_sp_t[fbase + k - 1], gap);
            end
        end
        chk("done_time", td_ - tb_, exp_done());
    endtask

    task automatic wait_done_a(output int td_);
        found = 0;
        td_ = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (done_a) begin found = 1; td_ = cyc; end
        end
        chk("done_a_timeout", found, 1);
    endtask

    initial begin
        rst_a = 1; rst_z = 1; rst_p = 1;
        start_a = 0; start_z = 0; start_p = 0;
        rand_tbl(0);
        repeat (3) @(negedge clk);

        chk("rst_sio_c", c_a, 1);
        chk("rst_sio_d", d_a, 1);
        chk("rst_sio_oe", oe_a, 0);
        chk("rst_idx", idx_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);

        rst_p = 0;
        repeat (5) @(negedge clk);
        chk("p_no_autostart", busy_p, 0);

        // Empty table: busy for the power-up wait plus one fetch cycle, no bus activity.
        rst_z = 0;
        found = 0; nb = 0; nlow = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (!c_z) nlow++;
            if (done_z) found = 1;
            else if (busy_z) nb++;
        end
        chk("z_done", found, 1);
        chk("z_busy_cycles", nb, Z_PW + 1);
        chk("z_busy_at_done", busy_z, 0);
        chk("z_sioc_low", nlow, 0);
        chk("z_idx", idx_z, 0);

        // Abort in the middle of the register byte (reg bit 5 on the bus).
        rst_a = 0;
        mon_en = 1;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (inf && mnb == 11) found = 1;
        end
        chk("mid_reach", found, 1);
        mon_en = 0;
        rst_a = 1;
        @(negedge clk);
        chk("mid_sio_c", c_a, 1);
        chk("mid_sio_oe", oe_a, 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_idx", idx_a, 0);
        rst_a = 0;
        sb = q_st_t.size();
        fb = q_fr.size();
        mon_en = 1;

        found = 0; t_b = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (busy_a) begin found = 1; t_b = cyc; end
        end
        chk("restart_busy", found, 1);

        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (q_st_t.size() >= sb + 2) found = 1;
        end
        chk("second_txn_seen", found, 1);
        r_ig = idx_a;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        @(negedge clk);
        chk("ign_idx_before", r_ig, 1);
        chk("ign_idx_after", idx_a, 1);
        chk("ign_busy", busy_a, 1);
        wait_done_a(t_d);
        check_run(sb, fb, t_b, t_d);

        // Restart from DONE with a fresh table.
        repeat (3) @(negedge clk);
        rand_tbl(int'($urandom_range(0, A_N - 1)));
        sb = q_st_t.size();
        fb = q_fr.size();
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        t_b = cyc;
        chk("rs_done_drop", done_a, 0);
        chk("rs_busy", busy_a, 1);
        chk("rs_idx", idx_a, 0);
        wait_done_a(t_d);
        check_run(sb, fb, t_b, t_d);
        @(negedge clk);
        chk("final_idx", idx_a, A_N);

        // Full-rate divider: SIO_C period and high time during data bits.
        start_p = 1;
        @(negedge clk);
        start_p = 0;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin @(negedge clk); if (!c_p) found = 1; end
        chk("p_first_fall", found, 1);
        found = 0; t1 = 0;
        for (int i = 0; i < 1000 && !found; i++) begin @(negedge clk); if (c_p) begin found = 1; t1 = cyc; end end
        chk("p_rise1", found, 1);
        found = 0; t2 = 0;
        for (int i = 0; i < 1000 && !found; i++) begin @(negedge clk); if (!c_p) begin found = 1; t2 = cyc; end end
        chk("p_fall", found, 1);
        found = 0; t3 = 0;
        for (int i = 0; i < 1000 && !found; i++) begin @(negedge clk); if (c_p) begin found = 1; t3 = cyc; end end
        chk("p_rise2", found, 1);
        chk("p_high_time", t2 - t1, 2 * P_CD);
        chk("p_period", t3 - t1, 4 * P_CD);
        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin @(negedge clk); if (done_p) found = 1; end
        chk("p_done", found, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
